// File: rtl/irq_controller.sv
// irq_controller
// Eight-line interrupt controller for the MIPS core. Each external line is
// synchronized, rising edges become sticky pending bits, a software mask
// selects which sources may interrupt, and the lowest-index enabled source
// is offered to the core through a req/ack handshake. A new request is only
// raised once the running handler has signalled end-of-interrupt.
module irq_controller #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       ph1,
    input  logic                       reset_b,
    input  logic [NUM_IRQ-1:0]         interrupts,
    input  logic                       mask_we,
    input  logic [NUM_IRQ-1:0]         mask_wdata,
    input  logic                       int_ack,
    input  logic                       eoi,
    output logic                       int_req,
    output logic [$clog2(NUM_IRQ)-1:0] int_id,
    output logic [NUM_IRQ-1:0]         pending,
    output logic [NUM_IRQ-1:0]         mask,
    output logic                       in_service
);

    localparam int ID_W = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] sync_out;
    logic [NUM_IRQ-1:0] edge_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] active;
    logic [ID_W-1:0]    winner;
    logic               have_winner;
    logic               ack_accept;
    logic               eoi_accept;

    // Synchronizer chain per line followed by the prev flop used for edge detection
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= interrupts;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Rising edge of each synchronized line, one cycle wide
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        edge_vec = sync_out & ~prev_q;
    end

    // Handshake inputs only count in the state where they are meaningful
    always_comb begin
        ack_accept = (state == REQ) && int_ack;
        eoi_accept = (state == SERVICE) && eoi;
    end

    // One-hot clear for the source being acknowledged
    always_comb begin
        clr_vec = '0;
        if (ack_accept) begin
            clr_vec[int_id] = 1'b1;
        end
    end

    // Software mask register; masked sources still latch into pending
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            mask <= '0;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end

    // Sticky pending bits; a fresh edge beats a same-cycle clear
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | edge_vec;
        end
    end

    // Lowest-index enabled pending source wins arbitration
    always_comb begin
        active      = pending & mask;
        winner      = '0;
        have_winner = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                winner      = i[ID_W-1:0];
                have_winner = 1'b1;
            end
        end
    end

    // Source index is captured when leaving IDLE and frozen until the next decision
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            int_id <= '0;
        end else if ((state == IDLE) && have_winner) begin
            int_id <= winner;
        end
    end

    // FSM state register
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; an ack together with eoi in REQ acts as ack only
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (have_winner) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (ack_accept) begin
                    next_state = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi_accept) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the state register only
    always_comb begin
        int_req    = 1'b0;
        in_service = 1'b0;
        case (state)
            REQ:     int_req    = 1'b1;
            SERVICE: in_service = 1'b1;
            default: begin
                int_req    = 1'b0;
                in_service = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
// Directed bench for irq_controller. Each expected request id is queued when
// its stimulus is issued; a monitor pops and compares on every new int_req.
module tb_irq_controller;

    logic       ph1;
    logic       reset_b;
    logic [7:0] interrupts;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       int_ack;
    logic       eoi;
    logic       int_req;
    logic [2:0] int_id;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       in_service;

    int checks;
    int errors;
    int exp_q[$];
    logic last_req;

    irq_controller #(
        .NUM_IRQ(8),
        .SYNC_STAGES(2)
    ) dut (
        .ph1(ph1),
        .reset_b(reset_b),
        .interrupts(interrupts),
        .mask_we(mask_we),
        .mask_wdata(mask_wdata),
        .int_ack(int_ack),
        .eoi(eoi),
        .int_req(int_req),
        .int_id(int_id),
        .pending(pending),
        .mask(mask),
        .in_service(in_service)
    );

    // Free-running clock
    initial begin
        ph1 = 1'b0;
        forever #5 ph1 = ~ph1;
    end

    // Monitor: every new request is compared against the queued expectation
    initial begin
        last_req = 1'b0;
        forever begin
            @(negedge ph1);
            if (int_req && !last_req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL req_unexpected: got int_id=%0d, required no request", int_id);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int_id !== e[2:0]) begin
                        errors++;
                        $display("[TB] FAIL req_id: got int_id=%0d, required %0d", int_id, e);
                    end
                end
            end
            last_req = int_req;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge ph1);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    // Raise the given lines for a number of cycles, then drop them
    task automatic applyStimulus(input logic [7:0] lines, input int width);
        interrupts = interrupts | lines;
        cyc(width);
        interrupts = interrupts & ~lines;
    endtask

    task automatic writeMask(input logic [7:0] value);
        mask_we    = 1'b1;
        mask_wdata = value;
        cyc();
        mask_we    = 1'b0;
    endtask

    task automatic waitReq(input string name);
        int n;
        n = 0;
        while (!int_req && n < 40) begin
            cyc();
            n++;
        end
        if (!int_req) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got int_req=0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic doAck();
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
    endtask

    task automatic doEoi();
        eoi = 1'b1;
        cyc();
        eoi = 1'b0;
    endtask

    initial begin
        bit saw_req;
        checks     = 0;
        errors     = 0;
        reset_b    = 1'b0;
        interrupts = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        int_ack    = 1'b0;
        eoi        = 1'b0;
        cyc(3);

        checkOutput("rst_int_req", 32'(int_req), 32'd0);
        checkOutput("rst_pending", 32'(pending), 32'h00);
        checkOutput("rst_mask", 32'(mask), 32'h00);
        checkOutput("rst_in_service", 32'(in_service), 32'd0);
        reset_b = 1'b1;
        cyc(2);

        // Single event with exact latencies
        writeMask(8'hFF);
        checkOutput("mask_ff", 32'(mask), 32'hFF);
        exp_q.push_back(1);
        interrupts = 8'h02;
        cyc(3);
        checkOutput("single_pending", 32'(pending), 32'h02);
        checkOutput("single_req_early", 32'(int_req), 32'd0);
        cyc();
        checkOutput("single_req", 32'(int_req), 32'd1);
        checkOutput("single_id", 32'(int_id), 32'd1);
        cyc();
        interrupts = 8'h00;
        doAck();
        checkOutput("single_ack_pending", 32'(pending), 32'h00);
        checkOutput("single_ack_insvc", 32'(in_service), 32'd1);
        checkOutput("single_ack_req", 32'(int_req), 32'd0);
        doEoi();
        checkOutput("single_eoi_insvc", 32'(in_service), 32'd0);
        cyc(5);
        checkOutput("single_idle_req", 32'(int_req), 32'd0);

        // Priority and request stability
        exp_q.push_back(2);
        exp_q.push_back(0);
        exp_q.push_back(5);
        applyStimulus(8'h24, 1);
        waitReq("prio_first");
        applyStimulus(8'h01, 1);
        cyc(4);
        checkOutput("prio_stable_id", 32'(int_id), 32'd2);
        checkOutput("prio_stable_pending", 32'(pending), 32'h25);
        doAck();
        doEoi();
        checkOutput("prio_gap_req", 32'(int_req), 32'd0);
        waitReq("prio_second");
        doAck();
        doEoi();
        waitReq("prio_third");
        doAck();
        checkOutput("prio_drained", 32'(pending), 32'h00);
        doEoi();

        // Edge during handler is held until eoi
        exp_q.push_back(1);
        applyStimulus(8'h02, 1);
        waitReq("handler_first");
        doAck();
        exp_q.push_back(1);
        applyStimulus(8'h02, 1);
        cyc(5);
        checkOutput("handler_pending", 32'(pending), 32'h02);
        checkOutput("handler_req", 32'(int_req), 32'd0);
        doEoi();
        checkOutput("handler_eoi_req", 32'(int_req), 32'd0);
        cyc();
        checkOutput("handler_rereq", 32'(int_req), 32'd1);
        checkOutput("handler_rereq_id", 32'(int_id), 32'd1);
        doAck();
        doEoi();

        // Masked source latches but does not request
        writeMask(8'h00);
        applyStimulus(8'h08, 1);
        saw_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (int_req) saw_req = 1'b1;
        end
        checkOutput("mask_no_req", 32'(saw_req), 32'd0);
        checkOutput("mask_pending", 32'(pending), 32'h08);
        exp_q.push_back(3);
        writeMask(8'h08);
        checkOutput("mask_w_req", 32'(int_req), 32'd0);
        cyc();
        checkOutput("mask_w1_req", 32'(int_req), 32'd1);
        checkOutput("mask_w1_id", 32'(int_id), 32'd3);
        doAck();
        doEoi();
        writeMask(8'hFF);

        // Edge on line 4 lands on the same edge as its ack
        exp_q.push_back(4);
        exp_q.push_back(4);
        applyStimulus(8'h10, 1);
        waitReq("setclr_first");
        cyc(2);
        interrupts = 8'h10;
        cyc();
        interrupts = 8'h00;
        cyc();
        doAck();
        checkOutput("setclr_pending", 32'(pending), 32'h10);
        checkOutput("setclr_insvc", 32'(in_service), 32'd1);
        doEoi();
        waitReq("setclr_second");
        doAck();
        checkOutput("setclr_cleared", 32'(pending), 32'h00);
        doEoi();

        // Asynchronous reset while a request is outstanding
        exp_q.push_back(6);
        applyStimulus(8'h40, 1);
        waitReq("reset_req");
        cyc();
        interrupts = 8'h80;
        #2;
        reset_b = 1'b0;
        #1;
        checkOutput("areset_req", 32'(int_req), 32'd0);
        checkOutput("areset_id", 32'(int_id), 32'd0);
        checkOutput("areset_pending", 32'(pending), 32'h00);
        checkOutput("areset_mask", 32'(mask), 32'h00);
        checkOutput("areset_insvc", 32'(in_service), 32'd0);
        cyc(2);
        #3;
        reset_b = 1'b1;
        cyc(6);
        checkOutput("held_pending", 32'(pending), 32'h80);
        checkOutput("held_masked_req", 32'(int_req), 32'd0);
        exp_q.push_back(7);
        writeMask(8'h80);
        waitReq("held_req");
        doAck();
        doEoi();
        cyc(10);
        checkOutput("held_once_pending", 32'(pending), 32'h00);
        checkOutput("held_once_req", 32'(int_req), 32'd0);
        interrupts = 8'h00;
        cyc(3);

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller sitting between the eight external `interrupts` lines and the MIPS core's exception logic. It synchronizes each line, turns rising edges into sticky pending bits, applies a software-written mask, and picks the highest-priority unmasked pending source. It then presents that source to the core through a request/acknowledge handshake and holds off further requests until the handler signals end-of-interrupt. Edges that arrive while a handler runs are latched but not delivered until the handler exits.

## Interface
- `NUM_IRQ`, 8: number of interrupt lines; `int_id` width is `$clog2(NUM_IRQ)`.
- `SYNC_STAGES`, 2: synchronizer flops per line (minimum 2).
- `ph1` input 1: sole clock, rising-edge.
- `reset_b` input 1: asynchronous, active-low reset.
- `interrupts` input NUM_IRQ: asynchronous external interrupt lines, active-high.
- `mask_we` input 1: write strobe for the mask register.
- `mask_wdata` input NUM_IRQ: new mask value (1 = enabled).
- `int_ack` input 1: core accepts the current request.
- `eoi` input 1: one-cycle end-of-interrupt pulse from the handler (eret path).
- `int_req` output 1: interrupt request to core.
- `int_id` output 3: index of the requested source; stable while `int_req` is high.
- `pending` output NUM_IRQ: pending register, readable by software.
- `mask` output NUM_IRQ: current mask register.
- `in_service` output 1: high from ack until `eoi`.

## Operation
- Synchronizer: each line goes through `SYNC_STAGES` flops, then a `prev` flop. The edge for a line is `sync_out & ~prev`.
- Pending: `pending[i]` is set on an edge for line i. It is cleared only when an `int_ack` is accepted while `int_id == i`.
  - If an edge and a clear for the same bit fall in the same cycle, the set wins and the bit stays 1.
- Level-high lines produce exactly one edge. Further requests need a low phase of at least `SYNC_STAGES`+1 cycles.
- Mask: loaded on `mask_we`. The update takes effect in the following cycle's arbitration. Masked sources still latch into `pending`.
- Priority: lowest index wins among the bits of `pending & mask`.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if `pending & mask` is non-zero, register the winner into `int_id` and go to REQ. Otherwise stay.
  - REQ: `int_req`=1. `int_id` is frozen. A mask write or a new higher-priority edge does not withdraw or change the request. On `int_ack`, clear `pending[int_id]` and go to SERVICE.
  - SERVICE: `int_req`=0, `in_service`=1. Edges keep latching. On `eoi`, go to IDLE.
- Ignored inputs:
  - `int_ack` outside REQ.
  - `eoi` outside SERVICE.
  - `int_ack` and `eoi` together in REQ: treat as ack only.
- Reset (any time, including mid-handshake): FSM goes to IDLE.
  - `int_req`=0, `int_id`=0, `in_service`=0.
  - `pending`=0, `mask`=0, all sync and `prev` flops cleared.
  - A line held high across reset release yields one edge after release.

## Timing
- `interrupts[i]` rising edge first sampled at `ph1` edge n.
  - With `SYNC_STAGES`=2, `pending[i]` is visible after edge n+2.
  - `int_req` is high after edge n+3, if enabled and the FSM is in IDLE.
- Ack at edge m (in REQ): `int_req` low and `in_service` high after m. `pending` bit cleared after m.
- `eoi` at edge e: FSM back in IDLE after e.
  - If work is still pending, `int_req` rises after e+1. This gives a minimum of one idle cycle between requests.
- `mask_we` at edge w: the new mask is used for the IDLE decision at edge w+1.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Single event:
  - Stimulus: mask=0xFF, pulse `interrupts[1]` high for 5 cycles.
  - Response: `pending`=0x02 after 2 cycles, `int_req`=1 with `int_id`=1 after 3. Ack clears `pending` to 0x00 and raises `in_service`. `eoi` returns to IDLE with `int_req` staying 0.
- Priority and stability:
  - Stimulus: pulse lines 5 and 2 in the same cycle.
  - Response: `int_id`=2. A line-0 pulse during REQ leaves `int_id`=2.
  - After ack and `eoi`: next request is `int_id`=0, then `int_id`=5. Each request waits for its own ack/`eoi`.
- Pulse during handler:
  - Stimulus: while in SERVICE, pulse line 1 again.
  - Response: `pending`=0x02 and `int_req` stays 0 until `eoi`. `int_req`=1 with `int_id`=1 on the cycle after IDLE is re-entered.
- Masking:
  - Stimulus: mask=0x00, pulse line 3.
  - Response: `pending`=0x08, `int_req` stays 0 for 20 cycles. Writing mask=0x08 gives `int_req`=1 with `int_id`=3 two cycles later.
- Simultaneous set and clear:
  - Stimulus: an edge on line 4 is detected in the same cycle as the ack of `int_id`=4.
  - Response: `pending[4]` stays 1. After `eoi`, a second request with `int_id`=4 is issued.
- Reset mid-operation:
  - Stimulus: assert `reset_b`=0 asynchronously while in REQ.
  - Response: `int_req`, `int_id`, `pending`, `mask` and `in_service` go to 0 immediately, without waiting for a clock.
  - A line held high across reset release produces exactly one pending event.
